// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES helpers: controller state encoding, S-box lookup, GF(2^8)
// xtime and the single-column MixColumns transform.
package aes_cipher_iter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the top byte, one row of 16 entries per line.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // S-box substitution of one byte
  function automatic logic [7:0] subbytef(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TABLE[idx -: 8];
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte 0 of the column sits in [31:24]
  function automatic logic [31:0] mixcolumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped
// on the final round) and AddRoundKey. Byte i of the state is row i%4,
// column i/4, with byte 0 in [127:120].
module aes_round
  import aes_cipher_iter_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [7:0]  sub_bytes [16];
  logic [7:0]  shifted   [16];
  logic [31:0] column    [4];
  logic [31:0] mixed     [4];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sub_bytes[i] = subbytef(state_in[127-8*i -: 8]);
  end

  // Row r rotates left by r columns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[4*c+r] = sub_bytes[4*((c+r)%4)+r];
    end
    assign column[c] = {shifted[4*c], shifted[4*c+1], shifted[4*c+2], shifted[4*c+3]};
    assign mixed[c]  = final_round ? column[c] : mixcolumn(column[c]);
    assign state_out[127-32*c -: 32] = mixed[c] ^ round_key[127-32*c -: 32];
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core, one round per clock, fed by the flat
// expanded-key bus from keyExpansion. Optional macro AES_KEY_LATCH_EN
// snapshots all round keys on the accepting edge so upstream may change
// the key while a block is in flight.
module aes_cipher_iter
  import aes_cipher_iter_pkg::*;
#(
  parameter int nk = 8,
  parameter int nb = 4,
  parameter int nr = 14
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              data_in,
  input  logic [32*nb*(nr+1)-1:0]   w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              data_out
);

  localparam int         KEY_BITS   = 32 * nb * (nr + 1);
  localparam logic [3:0] LAST_ROUND = 4'(nr);

  if (nr != nk + 6 || nb != 4) begin : g_bad_cfg
    $error("aes_cipher_iter: nb must be 4 and nr must equal nk+6");
  end

  state_t       state, state_next;
  logic [3:0]   counter, counter_next;
  logic [127:0] state_reg, state_reg_next;
  logic [127:0] data_out_next;
  logic         out_valid_next;

  logic [KEY_BITS-1:0] key_src;
  logic [127:0]        round_keys [0:nr];
  logic [127:0]        first_key;
  logic [127:0]        round_key_sel;
  logic [127:0]        round_out;
  logic                final_round;

`ifdef AES_KEY_LATCH_EN
  logic [KEY_BITS-1:0] key_bank;

  // Snapshot the whole key schedule when a block is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_bank <= '0;
    end else if (in_valid && in_ready) begin
      key_bank <= w;
    end
  end

  assign key_src = key_bank;
`else
  assign key_src = w;
`endif

  // Round key r is words 4r..4r+3 with word 4r in the top 32 bits
  for (genvar r = 0; r <= nr; r++) begin : g_rk
    assign round_keys[r] = {key_src[128*r      +: 32], key_src[128*r + 32 +: 32],
                            key_src[128*r + 64 +: 32], key_src[128*r + 96 +: 32]};
  end

  // The initial AddRoundKey happens on the accepting edge, straight from w
  assign first_key     = {w[31:0], w[63:32], w[95:64], w[127:96]};
  assign round_key_sel = round_keys[counter];
  assign final_round   = (counter == LAST_ROUND);

  aes_round u_round (
    .state_in    (state_reg),
    .round_key   (round_key_sel),
    .final_round (final_round),
    .state_out   (round_out)
  );

  // Controller and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      counter   <= '0;
      state_reg <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      state_reg <= state_reg_next;
      data_out  <= data_out_next;
      out_valid <= out_valid_next;
    end
  end

  // Next-state logic: accept in IDLE, iterate rounds, then hold the result
  always_comb begin
    state_next     = state;
    counter_next   = counter;
    state_reg_next = state_reg;
    data_out_next  = data_out;
    out_valid_next = out_valid;
    in_ready       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_reg_next = data_in ^ first_key;
          counter_next   = 4'd1;
          state_next     = ROUND;
        end
      end
      ROUND: begin
        if (counter == 4'd0 || counter > LAST_ROUND) begin
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          state_reg_next = round_out;
          if (final_round) begin
            data_out_next  = round_out;
            out_valid_next = 1'b1;
            counter_next   = '0;
            state_next     = HOLD;
          end else begin
            counter_next = counter + 4'd1;
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        counter_next   = '0;
        out_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Scoreboard bench for aes_cipher_iter: AES-128/192/256 instances, FIPS-197
// vectors, latency/throughput, output hold, mid-block reset and key change.
module tb_aes_cipher_iter;

  typedef struct {
    logic [127:0] data;
    int           accept_edge;
    bit           check_data;
  } exp_t;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_KEY_LATCH_EN
  localparam bit KEY_LATCHED = 1'b1;
`else
  localparam bit KEY_LATCHED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] data_in  [3];
  logic [127:0] data_out [3];
  logic [1407:0] w128;
  logic [1663:0] w192;
  logic [1919:0] w256;
  logic [1919:0] w256_orig;
  logic [1919:0] w256_alt;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_accept [3];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  logic [2:0]   prev_valid;
  logic [127:0] cur_exp [3];
  bit   [2:0]   cur_check;
  exp_t         mon_e;
  bit           mon_have;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_iter #(.nk(4), .nb(4), .nr(10)) dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .w(w128), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(data_out[0]));

  aes_cipher_iter #(.nk(6), .nb(4), .nr(12)) dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .w(w192), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(data_out[1]));

  aes_cipher_iter dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .data_in(data_in[2]), .w(w256), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .data_out(data_out[2]));

  // Independent key-schedule model: S-box built from GF(2^8) inverse + affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sboxModel(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] v);
    return {sboxModel(v[31:24]), sboxModel(v[23:16]), sboxModel(v[15:8]), sboxModel(v[7:0])};
  endfunction

  function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk, input int nr);
    logic [31:0]   wd [60];
    logic [31:0]   temp;
    logic [7:0]    rcon;
    logic [1919:0] res;
    rcon = 8'h01;
    res  = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = wd[i-1];
      if (i % nk == 0) begin
        temp = subWord({temp[23:0], temp[31:24]}) ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subWord(temp);
      end
      wd[i] = wd[i-nk] ^ temp;
    end
    for (int i = 0; i < 4*(nr+1); i++) res[32*i +: 32] = wd[i];
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input string detail);
    checks++;
    failures++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  // Caller must be just after a rising edge; pushes the expectation at accept
  task automatic applyStimulus(input int d, input logic [127:0] pt, input logic [127:0] ct, input bit check_data);
    bit   accepted;
    exp_t e;
    accepted    = 1'b0;
    in_valid[d] = 1'b1;
    data_in[d]  = pt;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      failNow($sformatf("accept timeout dut%0d", d), "in_ready never rose");
    end else begin
      e.data        = ct;
      e.accept_edge = cyc + 1;
      e.check_data  = check_data;
      last_accept[d] = cyc + 1;
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic waitOutput(input int d);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) failNow($sformatf("out_valid timeout dut%0d", d), "no ciphertext presented");
  endtask

  // Monitor: pop an expectation at each new output, then check it stays put while held
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        prev_valid[d] = 1'b0;
      end else begin
        if (out_valid[d] && !prev_valid[d]) begin
          mon_have = 1'b0;
          case (d)
            0:       if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
            1:       if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
            default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_have = 1'b1; end
          endcase
          if (!mon_have) begin
            cur_check[d] = 1'b0;
            failNow($sformatf("unexpected output dut%0d", d), $sformatf("data_out %h with nothing pending", data_out[d]));
          end else begin
            cur_exp[d]   = mon_e.data;
            cur_check[d] = mon_e.check_data;
            checkOutput($sformatf("latency dut%0d", d), 128'(cyc - mon_e.accept_edge), 128'(10 + 2*d));
            if (mon_e.check_data)
              checkOutput($sformatf("ciphertext dut%0d", d), data_out[d], mon_e.data);
          end
        end else if (out_valid[d] && prev_valid[d] && cur_check[d]) begin
          checkOutput($sformatf("held data dut%0d", d), data_out[d], cur_exp[d]);
        end
        prev_valid[d] = out_valid[d];
      end
    end
  end

  initial begin
    int first_accept;
    int hs_edge;
    logic [1919:0] tmp;
    rst_n      = 1'b0;
    in_valid   = 3'b000;
    out_ready  = 3'b111;
    prev_valid = 3'b000;
    cur_check  = 3'b000;
    for (int d = 0; d < 3; d++) begin
      data_in[d]  = '0;
      cur_exp[d]  = '0;
      last_accept[d] = 0;
    end
    tmp  = expandKey({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    w128 = tmp[1407:0];
    tmp  = expandKey({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    w192 = tmp[1663:0];
    w256_orig = expandKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    w256_alt  = expandKey(256'hf0e1d2c3b4a5968778695a4b3c2d1e0fffeeddccbbaa99887766554433221100, 8, 14);
    w256 = w256_orig;

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset out_valid dut%0d", d), 128'(out_valid[d]), 128'd0);
      checkOutput($sformatf("reset data_out dut%0d", d), data_out[d], 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after reset", 128'(in_ready[2]), 128'd1);

    // FIPS-197 vectors for each key size
    @(posedge clk); #1;
    applyStimulus(0, PT, CT128, 1'b1);
    waitOutput(0);
    @(posedge clk); #1;
    applyStimulus(1, PT, CT192, 1'b1);
    waitOutput(1);

    // AES-256 back to back with out_ready high: one block per nr+2 cycles
    @(posedge clk); #1;
    applyStimulus(2, PT, CT256, 1'b1);
    first_accept = last_accept[2];
    applyStimulus(2, PT, CT256, 1'b1);
    checkOutput("throughput spacing", 128'(last_accept[2] - first_accept), 128'd16);
    waitOutput(2);

    // Back-pressure: hold out_ready low while poking in_valid/data_in
    @(posedge clk); #1;
    out_ready[2] = 1'b0;
    applyStimulus(2, PT, CT256, 1'b1);
    waitOutput(2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid[2] = ~in_valid[2];
      data_in[2]  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checkOutput("hold in_ready", 128'(in_ready[2]), 128'd0);
      checkOutput("hold out_valid", 128'(out_valid[2]), 128'd1);
    end
    @(posedge clk); #1;
    out_ready[2] = 1'b1;
    hs_edge = cyc + 1;
    applyStimulus(2, PT, CT256, 1'b1);
    checkOutput("re-accept gap", 128'(last_accept[2] - hs_edge), 128'd1);
    waitOutput(2);

    // Asynchronous reset in the middle of a block
    @(posedge clk); #1;
    applyStimulus(2, PT, CT256, 1'b1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-block reset out_valid", 128'(out_valid[2]), 128'd0);
    checkOutput("mid-block reset data_out", data_out[2], 128'd0);
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready after mid-block reset", 128'(in_ready[2]), 128'd1);
    @(posedge clk); #1;
    applyStimulus(2, PT, CT256, 1'b1);
    waitOutput(2);

    // Key changes three rounds into a block
    @(posedge clk); #1;
    applyStimulus(2, PT, CT256, KEY_LATCHED);
    repeat (3) @(posedge clk);
    #1;
    w256 = w256_alt;
    waitOutput(2);
    @(posedge clk); #1;
    w256 = w256_orig;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 128'(q0.size() + q1.size() + q2.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #100000;
    failNow("global timeout", "simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] stopped by time limit");
  end

endmodule
